// File: rtl/ecap5_dproc_pkg.sv
// rtl/ecap5_dproc_pkg.sv - shared types for the write-back stage
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } load_size_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wbm_state_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    localparam int unsigned WB_DEPTH = 2;

    function automatic logic [31:0] addr_onehot(input logic [4:0] addr);
        return 32'd1 << addr;
    endfunction

endpackage

// File: rtl/wbm_load_align.sv
// rtl/wbm_load_align.sv - load data extraction, extension and misalignment detect
module load_align
    import ecap5_dproc_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic        i_load,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    logic [31:0] w_shifted;

    // Bring the addressed byte lane down to bit 0; upper lanes fill with zeros.
    assign w_shifted = i_data >> {i_offset, 3'b000};

    always_comb begin
        o_data       = i_data;
        o_misaligned = 1'b0;
        if (i_load) begin
            case (i_size)
                BYTE: begin
                    o_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
                end
                HALF: begin
                    o_data       = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
                    o_misaligned = i_offset[0];
                end
                default: begin
                    o_misaligned = (i_offset != 2'd0);
                end
            endcase
        end
    end

endmodule

// File: rtl/wbm.sv
// rtl/wbm.sv - write-back stage: 2-entry result buffer feeding the register file
module wbm
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [31:0] reg_data_i,
    input  logic        load_i,
    input  logic [1:0]  load_size_i,
    input  logic        load_unsigned_i,
    input  logic [1:0]  load_offset_i,
    input  logic        rf_stall_i,
    output logic        rf_write_o,
    output logic [4:0]  rf_addr_o,
    output logic [31:0] rf_data_o,
    output logic [31:0] pending_mask_o,
    output logic        misaligned_o
);

    wbm_state_t  r_state;
    wbm_state_t  w_next_state;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    wb_entry_t   r_buf [WB_DEPTH];

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_align_data;
    logic        w_align_mis;
    wb_entry_t   w_head;

    load_align u_load_align (
        .i_data       (reg_data_i),
        .i_load       (load_i),
        .i_size       (load_size_i),
        .i_unsigned   (load_unsigned_i),
        .i_offset     (load_offset_i),
        .o_data       (w_align_data),
        .o_misaligned (w_align_mis)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY:   if (w_push) w_next_state = ONE;
            ONE: begin
                if (w_push && !w_pop)      w_next_state = FULL;
                else if (!w_push && w_pop) w_next_state = EMPTY;
            end
            FULL:    if (w_pop) w_next_state = ONE;
            default: w_next_state = EMPTY;
        endcase
    end

    // Ready depends on occupancy only, so a pop in FULL does not open the slot this cycle.
    always_comb begin
        input_ready_o = (r_state != FULL);
        w_push        = input_valid_i && input_ready_o;
        w_pop         = (r_state != EMPTY) && !rf_stall_i;
    end

    assign w_head = r_buf[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= '{reg_write: reg_write_i && !w_align_mis,
                                 addr:      reg_addr_i,
                                 data:      w_align_data};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            rf_write_o   <= 1'b0;
            rf_addr_o    <= 5'd0;
            rf_data_o    <= 32'd0;
            misaligned_o <= 1'b0;
        end else begin
            misaligned_o <= w_push && w_align_mis;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr   <= ~r_rd_ptr;
                rf_write_o <= w_head.reg_write && (w_head.addr != 5'd0);
                rf_addr_o  <= w_head.addr;
                rf_data_o  <= w_head.data;
            end else begin
                rf_write_o <= 1'b0;
            end
        end
    end

    always_comb begin
        pending_mask_o = 32'd0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (((r_state == FULL) || ((r_state == ONE) && (r_rd_ptr == 1'(i)))) &&
                r_buf[i].reg_write && (r_buf[i].addr != 5'd0)) begin
                pending_mask_o = pending_mask_o | addr_onehot(r_buf[i].addr);
            end
        end
    end

endmodule

// File: tb/tb_wbm.sv
// tb/tb_wbm.sv - self-checking bench for wbm against a queue-based reference model
module tb_wbm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] reg_data_i;
    logic        load_i;
    logic [1:0]  load_size_i;
    logic        load_unsigned_i;
    logic [1:0]  load_offset_i;
    logic        rf_stall_i;
    logic        rf_write_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic [31:0] pending_mask_o;
    logic        misaligned_o;

    wbm dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .input_valid_i   (input_valid_i),
        .input_ready_o   (input_ready_o),
        .reg_write_i     (reg_write_i),
        .reg_addr_i      (reg_addr_i),
        .reg_data_i      (reg_data_i),
        .load_i          (load_i),
        .load_size_i     (load_size_i),
        .load_unsigned_i (load_unsigned_i),
        .load_offset_i   (load_offset_i),
        .rf_stall_i      (rf_stall_i),
        .rf_write_o      (rf_write_o),
        .rf_addr_o       (rf_addr_o),
        .rf_data_o       (rf_data_o),
        .pending_mask_o  (pending_mask_o),
        .misaligned_o    (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        exp_wr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_mis;
    bit          model_ok = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_extract(input logic [31:0] d, input logic ld, input logic [1:0] sz,
                                        input logic uns, input logic [1:0] off,
                                        output logic [31:0] r, output logic mis);
        logic [31:0] lane;
        r    = d;
        mis  = 1'b0;
        lane = d >> (8 * off);
        if (ld) begin
            if (sz == 2'd0) begin
                r = lane % 256;
                if (!uns && r >= 128) r = r - 256;
            end else if (sz == 2'd1) begin
                r = lane % 65536;
                if (!uns && r >= 32768) r = r - 65536;
                mis = (off % 2) == 1;
            end else begin
                mis = (off != 2'd0);
            end
        end
    endfunction

    always @(posedge clk_i) begin : model
        logic [31:0] d;
        logic        mis;
        bit          push;
        bit          pop;
        if (!rst_i) begin
            q.delete();
            exp_wr   = 1'b0;
            exp_addr = 5'd0;
            exp_data = 32'd0;
            exp_mis  = 1'b0;
            model_ok = 1'b1;
        end else begin
            push = input_valid_i && (q.size() < 2);
            pop  = (q.size() > 0) && !rf_stall_i;
            ref_extract(reg_data_i, load_i, load_size_i, load_unsigned_i, load_offset_i, d, mis);
            if (pop) begin
                exp_wr   = q[0].we && (q[0].addr != 5'd0);
                exp_addr = q[0].addr;
                exp_data = q[0].data;
                void'(q.pop_front());
            end else begin
                exp_wr = 1'b0;
            end
            exp_mis = push && load_i && mis;
            if (push) q.push_back('{we: reg_write_i && !(load_i && mis), addr: reg_addr_i, data: d});
        end
    end

    always @(negedge clk_i) begin : compare
        logic [31:0] m;
        if (model_ok) begin
            m = 32'd0;
            foreach (q[i]) if (q[i].we && q[i].addr != 5'd0) m = m | (32'd1 << q[i].addr);
            chk("ready", input_ready_o, q.size() < 2);
            chk("rf_write", rf_write_o, exp_wr);
            chk("rf_addr", rf_addr_o, exp_addr);
            chk("rf_data", rf_data_o, exp_data);
            chk("misaligned", misaligned_o, exp_mis);
            chk("pending", pending_mask_o, m);
        end
    end

    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d, input logic ld,
                         input logic [1:0] sz, input logic uns, input logic [1:0] off);
        input_valid_i   = 1'b1;
        reg_write_i     = we;
        reg_addr_i      = a;
        reg_data_i      = d;
        load_i          = ld;
        load_size_i     = sz;
        load_unsigned_i = uns;
        load_offset_i   = off;
    endtask

    // Holds the current input until an edge accepts it; returns just after that edge.
    task automatic wait_accept(input string name);
        int   k;
        logic rdy;
        k = 0;
        do begin
            rdy = input_ready_o;
            @(posedge clk_i);
            #1;
            k++;
        end while (!rdy && k < 50);
        input_valid_i = 1'b0;
        n_checks++;
        if (!rdy) begin
            n_errors++;
            $display("FAIL %s: not accepted within %0d cycles", name, k);
        end
    endtask

    task automatic send(input string name, input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic ld, input logic [1:0] sz, input logic uns, input logic [1:0] off);
        drive(we, a, d, ld, sz, uns, off);
        wait_accept(name);
    endtask

    task automatic after_pop();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        rf_stall_i = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        input_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_ready", input_ready_o, 32'd1);
        chk("reset_rf_write", rf_write_o, 32'd0);
        chk("reset_rf_data", rf_data_o, 32'd0);
        chk("reset_pending", pending_mask_o, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        send("byte_load", 1'b1, 5'd5, 32'h11223380, 1'b1, 2'd0, 1'b0, 2'd0);
        after_pop();
        chk("byte_rf_write", rf_write_o, 32'd1);
        chk("byte_rf_addr", rf_addr_o, 32'd5);
        chk("byte_rf_data", rf_data_o, 32'hFFFFFF80);

        send("half_u", 1'b1, 5'd3, 32'h80017FFF, 1'b1, 2'd1, 1'b1, 2'd2);
        after_pop();
        chk("half_unsigned", rf_data_o, 32'h00008001);
        send("half_s", 1'b1, 5'd3, 32'h80017FFF, 1'b1, 2'd1, 1'b0, 2'd2);
        after_pop();
        chk("half_signed", rf_data_o, 32'hFFFF8001);

        send("addr0", 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 2'd2, 1'b0, 2'd0);
        after_pop();
        chk("addr0_no_write", rf_write_o, 32'd0);

        send("misaligned", 1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, 2'd2);
        @(negedge clk_i);
        chk("mis_pulse", misaligned_o, 32'd1);
        chk("mis_pending7", 32'(pending_mask_o[7]), 32'd0);
        after_pop();
        chk("mis_pulse_end", misaligned_o, 32'd0);
        chk("mis_no_write", rf_write_o, 32'd0);

        rf_stall_i = 1'b1;
        send("stall_a", 1'b1, 5'd1, 32'hA1A1A1A1, 1'b0, 2'd2, 1'b0, 2'd0);
        send("stall_b", 1'b1, 5'd2, 32'hB2B2B2B2, 1'b0, 2'd2, 1'b0, 2'd0);
        chk("stall_full_ready", input_ready_o, 32'd0);
        chk("stall_pending", pending_mask_o, 32'h00000006);
        drive(1'b1, 5'd3, 32'hC3C3C3C3, 1'b0, 2'd2, 1'b0, 2'd0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("stall_hold_ready", input_ready_o, 32'd0);
        chk("stall_hold_nowrite", rf_write_o, 32'd0);
        rf_stall_i = 1'b0;
        @(negedge clk_i);
        chk("order_first", rf_data_o, 32'hA1A1A1A1);
        wait_accept("stall_c");
        @(negedge clk_i);
        chk("order_second", rf_addr_o, 32'd2);
        after_pop();
        chk("order_third", rf_data_o, 32'hC3C3C3C3);

        rf_stall_i = 1'b1;
        send("rst_a", 1'b1, 5'd8, 32'h88888888, 1'b0, 2'd2, 1'b0, 2'd0);
        send("rst_b", 1'b1, 5'd9, 32'h99999999, 1'b0, 2'd2, 1'b0, 2'd0);
        chk("rst_pending_before", pending_mask_o, 32'h00000300);
        rst_i = 1'b0;
        after_pop();
        chk("rst_pending_after", pending_mask_o, 32'd0);
        chk("rst_ready_after", input_ready_o, 32'd1);
        rst_i = 1'b1;
        rf_stall_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            chk("rst_no_write", rf_write_o, 32'd0);
        end

        repeat (3000) begin
            @(negedge clk_i);
            rst_i      = ($urandom_range(0, 249) != 0);
            rf_stall_i = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 7) != 0,
                  ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
                  $urandom, $urandom_range(0, 1) != 0, 2'($urandom), 1'($urandom), 2'($urandom));
            input_valid_i = ($urandom_range(0, 2) != 0);
        end

        @(negedge clk_i);
        rst_i = 1'b1;
        rf_stall_i = 1'b0;
        input_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
